// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the TDM demultiplexer.
package tdm_pkg;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage : tdm_pkg

// File: rtl/tdm_demux_slot_counter.sv
// Slot select counter: loads to 1 on a sync beat, steps on locked valid beats,
// and flags the last slot of the frame.
module slot_counter
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_load,
  output logic [SEL_W-1:0] o_cnt,
  output logic             o_wrap_c
);

  logic [SEL_W-1:0] r_cnt;

  // Slot 0 has just been captured on a load, so the next valid beat goes to slot 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= SEL_W'(1);
    end else if (i_en) begin
      r_cnt <= r_cnt + SEL_W'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_wrap_c = (r_cnt == SEL_W'(CHANNELS - 1));

endmodule : slot_counter

// File: rtl/tdm_demux.sv
// Serial-to-parallel 4-slot TDM demultiplexer: locks to frame sync, stages
// slot bits and publishes a complete frame word once per frame.
module tdm_demux
  import tdm_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  input  logic                din_valid,
  input  logic                sync,
  output logic [CHANNELS-1:0] Y,
  output logic [SEL_W-1:0]    S,
  output logic                frame_done,
  output logic                sync_err
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CHANNELS-2:0] r_stage;
  logic [CHANNELS-2:0] w_stage_nxt;
  logic [CHANNELS-1:0] r_y;
  logic [CHANNELS-1:0] w_y_nxt;
  logic                r_frame_done;
  logic                w_frame_done_nxt;
  logic                r_sync_err;
  logic                w_sync_err_nxt;
  logic [SEL_W-1:0]    w_slot;
  logic                w_wrap;
  logic                w_cnt_en;
  logic                w_cnt_load;

  assign w_cnt_en   = din_valid && (r_state == LOCKED);
  assign w_cnt_load = din_valid && sync;

  slot_counter u_slot_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_cnt_en),
    .i_load   (w_cnt_load),
    .o_cnt    (w_slot),
    .o_wrap_c (w_wrap)
  );

  // State, staging, output word and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= HUNT;
      r_stage      <= '0;
      r_y          <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_stage      <= w_stage_nxt;
      r_y          <= w_y_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_sync_err   <= w_sync_err_nxt;
    end
  end

  // Next state: a sync beat always restarts the frame at slot 0; the slot-3
  // beat publishes the staged bits plus the incoming bit as one word.
  always_comb begin
    w_state_nxt      = r_state;
    w_stage_nxt      = r_stage;
    w_y_nxt          = r_y;
    w_frame_done_nxt = 1'b0;
    w_sync_err_nxt   = 1'b0;
    if (din_valid) begin
      case (r_state)
        HUNT: begin
          if (sync) begin
            w_stage_nxt = (CHANNELS - 1)'(din);
            w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            w_sync_err_nxt = (w_slot != '0);
            w_stage_nxt    = (CHANNELS - 1)'(din);
          end else if (w_wrap) begin
            w_y_nxt          = {din, r_stage};
            w_frame_done_nxt = 1'b1;
          end else begin
            w_stage_nxt[w_slot] = din;
          end
        end
        default: begin
          w_state_nxt = HUNT;
        end
      endcase
    end
  end

  assign Y          = r_y;
  assign S          = w_slot;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;

endmodule : tdm_demux
